// File: rtl/pong_pkg.sv
// Shared types and constants for the Pong game timing blocks.
package pong_pkg;

    // Countdown timer control states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2,
        DONE   = 2'd3
    } timer_state_t;

    // Default count width for game timers
    localparam int TIMER_W_DEFAULT = 10;

endpackage

// File: rtl/tick_prescaler.sv
// Divides the clock into one tick every PRESCALE enabled cycles.
// The counter only advances while enabled, so pausing the owner freezes it mid-count.
module tick_prescaler #(
    parameter int PRESCALE = 4
) (
    input  logic i_clock,
    input  logic i_reset_n,
    input  logic i_enable,
    input  logic i_clear,
    output logic o_tick
);

    // One extra bit keeps PRESCALE=1 legal and leaves headroom for exact powers of two
    localparam int CW = $clog2(PRESCALE) + 1;
    localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

    logic [CW-1:0] r_count;
    logic          w_at_last;

    assign w_at_last = (r_count == LAST);
    assign o_tick    = i_enable && w_at_last;

    // Wrapping cycle counter; clear wins over enable
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= w_at_last ? '0 : r_count + 1'b1;
        end
    end

endmodule

// File: rtl/down_counter_timer.sv
// Loadable, pausable countdown timer with saturating terminal count,
// one-cycle expiry pulse and optional auto-reload of the last loaded value.
module down_counter_timer
    import pong_pkg::*;
#(
    parameter int WIDTH     = TIMER_W_DEFAULT,
    parameter int DECREMENT = 1,
    parameter int PRESCALE  = 4,
    parameter int MIN_VALUE = 0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             start,
    input  logic             pause,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] countValue,
    output logic             running,
    output logic             expired,
    output logic             done
);

    // Step size and terminal count live at the count width
    localparam logic [WIDTH-1:0] DEC_W = WIDTH'(DECREMENT);
    localparam logic [WIDTH-1:0] MIN_W = WIDTH'(MIN_VALUE);

    timer_state_t     r_state;
    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] r_reload;
    logic             r_running;
    logic             r_expired;
    logic             r_done;

    logic             w_pause_req;
    logic             w_presc_en;
    logic             w_tick;
    logic [WIDTH-1:0] w_delta;
    logic             w_last_step;

    // start outranks pause, so a simultaneous start keeps the timer running
    assign w_pause_req = pause && !start;
    // Prescaler only advances on cycles where RUN actually continues counting
    assign w_presc_en  = (r_state == RUN) && !load && !w_pause_req;
    // Distance to terminal count decides between saturation and a plain decrement
    assign w_delta     = r_count - MIN_W;
    assign w_last_step = (w_delta <= DEC_W);

    tick_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .i_clock   (clock),
        .i_reset_n (reset),
        .i_enable  (w_presc_en),
        .i_clear   (load),
        .o_tick    (w_tick)
    );

    // Control FSM with count/reload registers and registered status outputs
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_count   <= MIN_W;
            r_reload  <= '0;
            r_running <= 1'b0;
            r_expired <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_expired <= 1'b0;
            if (load) begin
                r_count   <= load_value;
                r_reload  <= load_value;
                r_state   <= start ? RUN : IDLE;
                r_running <= start;
                r_done    <= 1'b0;
            end else if (start && (r_state != RUN)) begin
                // Restarting after expiry resumes from the last loaded value
                if (r_state == DONE) begin
                    r_count <= r_reload;
                end
                r_state   <= RUN;
                r_running <= 1'b1;
                r_done    <= 1'b0;
            end else if (w_pause_req && (r_state == RUN)) begin
                r_state   <= PAUSED;
                r_running <= 1'b0;
            end else if (w_tick) begin
                if (w_last_step) begin
                    r_expired <= 1'b1;
                    if (auto_reload) begin
                        r_count <= r_reload;
                    end else begin
                        r_count   <= MIN_W;
                        r_state   <= DONE;
                        r_running <= 1'b0;
                        r_done    <= 1'b1;
                    end
                end else begin
                    r_count <= r_count - DEC_W;
                end
            end
        end
    end

    assign countValue = r_count;
    assign running    = r_running;
    assign expired    = r_expired;
    assign done       = r_done;

endmodule

// File: tb/tb_down_counter_timer.sv
// Bench for down_counter_timer: three instances share one stimulus bus
// (PRESCALE=4, PRESCALE=1, DECREMENT=3); each scenario observes one of them.
module tb_down_counter_timer;

    typedef struct packed {
        logic [9:0] cnt;
        logic       run;
        logic       exp;
        logic       dn;
    } obs_t;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       load = 1'b0;
    logic [9:0] load_value = '0;
    logic       start = 1'b0;
    logic       pause = 1'b0;
    logic       auto_reload = 1'b0;

    logic [9:0] cnt_p4, cnt_p1, cnt_d3;
    logic       run_p4, run_p1, run_d3;
    logic       exp_p4, exp_p1, exp_d3;
    logic       dn_p4, dn_p1, dn_d3;

    int   sel = 0;
    obs_t obs;
    obs_t sb[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clock = ~clock;

    down_counter_timer #(.WIDTH(10), .DECREMENT(1), .PRESCALE(4), .MIN_VALUE(0)) u_p4 (
        .clock(clock), .reset(reset), .load(load), .load_value(load_value),
        .start(start), .pause(pause), .auto_reload(auto_reload),
        .countValue(cnt_p4), .running(run_p4), .expired(exp_p4), .done(dn_p4)
    );

    down_counter_timer #(.WIDTH(10), .DECREMENT(1), .PRESCALE(1), .MIN_VALUE(0)) u_p1 (
        .clock(clock), .reset(reset), .load(load), .load_value(load_value),
        .start(start), .pause(pause), .auto_reload(auto_reload),
        .countValue(cnt_p1), .running(run_p1), .expired(exp_p1), .done(dn_p1)
    );

    down_counter_timer #(.WIDTH(10), .DECREMENT(3), .PRESCALE(1), .MIN_VALUE(0)) u_d3 (
        .clock(clock), .reset(reset), .load(load), .load_value(load_value),
        .start(start), .pause(pause), .auto_reload(auto_reload),
        .countValue(cnt_d3), .running(run_d3), .expired(exp_d3), .done(dn_d3)
    );

    always_comb begin
        obs = '{cnt: cnt_p4, run: run_p4, exp: exp_p4, dn: dn_p4};
        case (sel)
            1:       obs = '{cnt: cnt_p1, run: run_p1, exp: exp_p1, dn: dn_p1};
            2:       obs = '{cnt: cnt_d3, run: run_d3, exp: exp_d3, dn: dn_d3};
            default: ;
        endcase
    end

    function automatic obs_t mk(input int c, input bit r, input bit x, input bit d);
        obs_t o;
        o.cnt = 10'(c);
        o.run = r;
        o.exp = x;
        o.dn  = d;
        return o;
    endfunction

    task automatic test_reset();
        obs_t want;
        want = mk(0, 0, 0, 0);
        #2;
        for (int i = 0; i < 3; i++) begin
            sel = i;
            #1;
            checks++;
            if (obs !== want) begin
                errors++;
                $display("FAIL reset_state inst=%0d got cnt=%0d run=%b exp=%b done=%b want all zero",
                         i, obs.cnt, obs.run, obs.exp, obs.dn);
            end
        end
        sel = 0;
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic test_async_reset();
        obs_t e;
        sel = 0;
        @(negedge clock);
        load = 1'b1; load_value = 10'd7; start = 1'b1;
        sb.push_back(mk(7, 1, 0, 0));
        sb.push_back(mk(7, 1, 0, 0));
        for (int k = 0; k < 2; k++) begin
            @(negedge clock);
            load = 1'b0; start = 1'b0;
            e = sb.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL async_pre k=%0d got cnt=%0d run=%b want cnt=%0d run=%b",
                         k, obs.cnt, obs.run, e.cnt, e.run);
            end
        end
        // Assert reset between clock edges and look before any edge arrives
        #2 reset = 1'b0;
        #1;
        checks++;
        if (obs !== mk(0, 0, 0, 0)) begin
            errors++;
            $display("FAIL async_assert got cnt=%0d run=%b exp=%b done=%b want cnt=0 run=0",
                     obs.cnt, obs.run, obs.exp, obs.dn);
        end
        @(negedge clock);
        reset = 1'b1;
        for (int k = 0; k < 3; k++) sb.push_back(mk(0, 0, 0, 0));
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            e = sb.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL async_idle k=%0d got cnt=%0d run=%b exp=%b done=%b want idle zeros",
                         k, obs.cnt, obs.run, obs.exp, obs.dn);
            end
        end
    endtask

    task automatic test_countdown();
        obs_t e;
        int   k;
        sel = 0;
        @(negedge clock);
        load = 1'b1; load_value = 10'd3;
        @(negedge clock);
        load = 1'b0; start = 1'b1;
        checks++;
        if (obs !== mk(3, 0, 0, 0)) begin
            errors++;
            $display("FAIL count_loaded got cnt=%0d run=%b want cnt=3 run=0", obs.cnt, obs.run);
        end
        for (int v = 3; v >= 1; v--)
            for (int r = 0; r < 4; r++) sb.push_back(mk(v, 1, 0, 0));
        sb.push_back(mk(0, 0, 1, 1));
        sb.push_back(mk(0, 0, 0, 1));
        sb.push_back(mk(0, 0, 0, 1));
        k = 0;
        while (sb.size() > 0) begin
            @(negedge clock);
            start = 1'b0;
            e = sb.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL countdown k=%0d got cnt=%0d run=%b exp=%b done=%b want cnt=%0d run=%b exp=%b done=%b",
                         k, obs.cnt, obs.run, obs.exp, obs.dn, e.cnt, e.run, e.exp, e.dn);
            end
            k++;
        end
    endtask

    task automatic test_pause();
        obs_t e;
        int   k;
        sel = 1;
        @(negedge clock);
        load = 1'b1; load_value = 10'd5; start = 1'b1;
        sb.push_back(mk(5, 1, 0, 0));
        sb.push_back(mk(4, 1, 0, 0));
        sb.push_back(mk(3, 1, 0, 0));
        for (int i = 0; i < 10; i++) sb.push_back(mk(3, 0, 0, 0));
        sb.push_back(mk(3, 1, 0, 0));
        sb.push_back(mk(2, 1, 0, 0));
        k = 0;
        while (sb.size() > 0) begin
            @(negedge clock);
            e = sb.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL pause k=%0d got cnt=%0d run=%b exp=%b done=%b want cnt=%0d run=%b exp=%b done=%b",
                         k, obs.cnt, obs.run, obs.exp, obs.dn, e.cnt, e.run, e.exp, e.dn);
            end
            if (k == 0) begin load = 1'b0; start = 1'b0; end
            if (k == 2) pause = 1'b1;
            if (k == 12) begin pause = 1'b0; start = 1'b1; end
            if (k == 13) start = 1'b0;
            k++;
        end
    endtask

    task automatic test_auto_reload();
        obs_t e;
        int   k;
        sel = 1;
        @(negedge clock);
        load = 1'b1; load_value = 10'd2; start = 1'b1; auto_reload = 1'b1;
        sb.push_back(mk(2, 1, 0, 0));
        for (int i = 0; i < 3; i++) begin
            sb.push_back(mk(1, 1, 0, 0));
            sb.push_back(mk(2, 1, 1, 0));
        end
        sb.push_back(mk(1, 1, 0, 0));
        sb.push_back(mk(0, 0, 1, 1));
        sb.push_back(mk(2, 1, 0, 0));
        sb.push_back(mk(1, 1, 0, 0));
        k = 0;
        while (sb.size() > 0) begin
            @(negedge clock);
            e = sb.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL auto_reload k=%0d got cnt=%0d run=%b exp=%b done=%b want cnt=%0d run=%b exp=%b done=%b",
                         k, obs.cnt, obs.run, obs.exp, obs.dn, e.cnt, e.run, e.exp, e.dn);
            end
            if (k == 0) begin load = 1'b0; start = 1'b0; end
            if (k == 6) auto_reload = 1'b0;
            if (k == 8) start = 1'b1;
            if (k == 9) start = 1'b0;
            k++;
        end
    endtask

    task automatic test_saturate();
        obs_t e;
        int   k;
        sel = 2;
        @(negedge clock);
        load = 1'b1; load_value = 10'd7; start = 1'b1;
        sb.push_back(mk(7, 1, 0, 0));
        sb.push_back(mk(4, 1, 0, 0));
        sb.push_back(mk(1, 1, 0, 0));
        sb.push_back(mk(0, 0, 1, 1));
        sb.push_back(mk(0, 0, 0, 1));
        k = 0;
        while (sb.size() > 0) begin
            @(negedge clock);
            load = 1'b0; start = 1'b0;
            e = sb.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL saturate k=%0d got cnt=%0d run=%b exp=%b done=%b want cnt=%0d run=%b exp=%b done=%b",
                         k, obs.cnt, obs.run, obs.exp, obs.dn, e.cnt, e.run, e.exp, e.dn);
            end
            k++;
        end
    endtask

    task automatic test_simultaneous();
        obs_t e;
        int   k;
        sel = 0;
        @(negedge clock);
        load = 1'b1; start = 1'b1; pause = 1'b1; load_value = 10'd9;
        for (int i = 0; i < 4; i++) sb.push_back(mk(9, 1, 0, 0));
        sb.push_back(mk(8, 1, 0, 0));
        for (int i = 0; i < 4; i++) sb.push_back(mk(0, 1, 0, 0));
        sb.push_back(mk(0, 0, 1, 1));
        sb.push_back(mk(0, 0, 0, 1));
        k = 0;
        while (sb.size() > 0) begin
            @(negedge clock);
            e = sb.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL simultaneous k=%0d got cnt=%0d run=%b exp=%b done=%b want cnt=%0d run=%b exp=%b done=%b",
                         k, obs.cnt, obs.run, obs.exp, obs.dn, e.cnt, e.run, e.exp, e.dn);
            end
            if (k == 0) begin load = 1'b0; start = 1'b0; pause = 1'b0; end
            if (k == 1) start = 1'b1;
            if (k == 2) start = 1'b0;
            if (k == 4) begin load = 1'b1; load_value = 10'd0; start = 1'b1; end
            if (k == 5) begin load = 1'b0; start = 1'b0; end
            k++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_async_reset();
        test_countdown();
        test_pause();
        test_auto_reload();
        test_saturate();
        test_simultaneous();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
